divider: RTL and testbench
==========================

Name: divider

Overview:
- Sequential signed 8-bit restoring divider: the inverse-operation companion to the 8-bit shift-add multiplier on the same board.
- Uses the same switch/pushbutton front end:
  - Reset_Load_Clear loads the dividend from SW.
  - Run divides it by the divisor presented on SW.
- Quotient appears on Bval, remainder on Aval, both shown on four hex displays.
- Results chain: the quotient in Bval is the dividend of the next Run.

Parameters:
- WIDTH, 8, operand/result width (all values below assume 8).
- HEX_ACTIVE_LOW, 1, 1 = segment outputs active-low.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Run  in  1  start pushbutton, active-low, asynchronous to operation; synchronised internally (2 flops) before use.
- Reset_Load_Clear  in  1  load pushbutton, active-low; synchronised internally.
- SW  in  8  switches: dividend on load, divisor on Run.
- Aval  out  8  remainder register (signed).
- Bval  out  8  quotient register / loaded dividend (signed).
- DivZero  out  1  last Run had divisor 0.
- Ovf  out  1  last Run was -128 / -1.
- HEX0..HEX3  out  7 each  seven-segment digits of Bval[3:0], Bval[7:4], Aval[3:0], Aval[7:4]; combinational decode of the registers.

Behaviour:
- Reset low (async): state IDLE, Aval=0, Bval=0, DivZero=0, Ovf=0, counter=0, internal working regs 0; HEX all show "0".
- States and transitions:
  - IDLE: synchronised Reset_Load_Clear low → Bval<=SW, Aval<=0, flags<=0, stay IDLE. Synchronised Run low → LOAD. If both are low, load wins and Run is ignored that cycle.
  - LOAD (1 cycle):
    - Sd=Bval[7], Sv=SW[7].
    - Q<=|Bval|, M<=|SW| (8-bit unsigned, |−128|=128), A(9-bit)<=0, cnt<=0, flags<=0.
    - M==0 → ZERO, else ITER.
  - ITER (exactly 8 cycles, cnt 0..7):
    - {A,Q} shifted left 1; T=A−{0,M}.
    - T≥0: A<=T, Q[0]<=1; else Q[0]<=0.
    - After cnt==7 → FIX.
  - FIX (1 cycle):
    - Bval <= (Sd^Sv) ? −Q : Q (low 8 bits).
    - Aval <= Sd ? −A[7:0] : A[7:0] (truncation toward zero; remainder takes the dividend's sign).
    - Ovf<=1 iff dividend=0x80 and divisor=0xFF (Bval becomes 0x80). → DONE.
  - ZERO (1 cycle): Bval<=0xFF, Aval<=dividend (unchanged Bval value before Run), DivZero<=1 → DONE.
  - DONE: hold all outputs until synchronised Run high → IDLE. Reset_Load_Clear is ignored in DONE.
- Aval/Bval keep their pre-Run values throughout LOAD/ITER; they change only in FIX/ZERO.
- Latency:
  - Edge on which synchronised Run is first seen low = edge 1 (IDLE→LOAD).
  - Results registered on edge 11 (normal) or edge 3 (divide-by-zero).
- Holding Run low for any duration performs exactly one division.
- Reset_Load_Clear during LOAD/ITER/FIX/ZERO is ignored.
- Reset asserted mid-operation aborts immediately to reset values; no partial result is written.
- Run synchroniser output resets to "released" (high), so Run held low through reset release starts one division after 2 synchroniser cycles.

Test Plan:
- Reset; load SW=0x3B (59); Run with SW=0x07 → after edge 11, Bval=0x08, Aval=0x03, DivZero=0, Ovf=0; HEX1..0="08", HEX3..2="03".
- Load 0xC5 (−59), Run SW=0x07 → Bval=0xF8 (−8), Aval=0xFD (−3). Load 0x3B, Run SW=0xF9 (−7) → Bval=0xF8, Aval=0x03. Load 0xC5, Run SW=0xF9 → Bval=0x08, Aval=0xFD.
- Load 0x3B, Run SW=0x00 → DivZero=1, Bval=0xFF, Aval=0x3B on edge 3. Load 0x80, Run SW=0xFF → Bval=0x80, Aval=0x00, Ovf=1, DivZero=0.
- Chaining and hold:
  - Load 0x64 (100); Run SW=0x03 held low 40 cycles → Bval=0x21, Aval=0x01, exactly one division.
  - Release; Run again SW=0x03 without reload → Bval=0x0B, Aval=0x00.
- Reset pulled low during ITER cycle cnt=4 → Aval=Bval=0, flags 0, state IDLE immediately. Reset_Load_Clear pulsed during ITER → Bval unaffected; final result matches an undisturbed run.

Source files
------------

// File: rtl/divider.sv
// ============================================================================
// divider -- sequential signed restoring divider with pushbutton front end
// Revision 1.0
// ============================================================================
`default_nettype none

module divider #(
    parameter int WIDTH          = 8,
    parameter bit HEX_ACTIVE_LOW = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Reset_Load_Clear,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             DivZero,
    output logic             Ovf,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_ZERO = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t state, state_next;

    logic run_s1, run_s2;
    logic load_s1, load_s2;
    logic run_req, load_req;

    logic [WIDTH:0]     a;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   m;
    logic [CNT_W-1:0]   cnt;
    logic               sd;
    logic               sv;
    logic               ovf_pend;

    logic [WIDTH+1:0]   a_sh;
    logic [WIDTH+1:0]   diff;
    logic               ge;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + ONE) : v;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return HEX_ACTIVE_LOW ? ~s : s;
    endfunction

    // Pushbuttons idle high, so synchronisers reset to the released level.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_s1  <= 1'b1;
            run_s2  <= 1'b1;
            load_s1 <= 1'b1;
            load_s2 <= 1'b1;
        end else begin
            run_s1  <= Run;
            run_s2  <= run_s1;
            load_s1 <= Reset_Load_Clear;
            load_s2 <= load_s1;
        end
    end

    assign run_req  = ~run_s2;
    assign load_req = ~load_s2;

    // One restoring step; the top bit of diff is the borrow of the trial subtract.
    assign a_sh = {a, q[WIDTH-1]};
    assign diff = a_sh - {2'b00, m};
    assign ge   = ~diff[WIDTH+1];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (load_req) begin
                    state_next = S_IDLE;
                end else if (run_req) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD:  state_next = (SW == '0) ? S_ZERO : S_ITER;
            S_ITER: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_DONE;
            S_ZERO:  state_next = S_DONE;
            S_DONE: begin
                if (!run_req) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Aval     <= '0;
            Bval     <= '0;
            DivZero  <= 1'b0;
            Ovf      <= 1'b0;
            a        <= '0;
            q        <= '0;
            m        <= '0;
            cnt      <= '0;
            sd       <= 1'b0;
            sv       <= 1'b0;
            ovf_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_req) begin
                        Bval    <= SW;
                        Aval    <= '0;
                        DivZero <= 1'b0;
                        Ovf     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    sd       <= Bval[WIDTH-1];
                    sv       <= SW[WIDTH-1];
                    q        <= magnitude(Bval);
                    m        <= magnitude(SW);
                    a        <= '0;
                    cnt      <= '0;
                    DivZero  <= 1'b0;
                    Ovf      <= 1'b0;
                    ovf_pend <= (Bval == MOST_NEG) && (SW == '1);
                end
                S_ITER: begin
                    a   <= ge ? diff[WIDTH:0] : a_sh[WIDTH:0];
                    q   <= {q[WIDTH-2:0], ge};
                    cnt <= cnt + CNT_ONE;
                end
                S_FIX: begin
                    // Truncating division: remainder carries the dividend's sign.
                    Bval <= (sd ^ sv) ? (~q + ONE) : q;
                    Aval <= sd ? (~a[WIDTH-1:0] + ONE) : a[WIDTH-1:0];
                    Ovf  <= ovf_pend;
                end
                S_ZERO: begin
                    Aval    <= Bval;
                    Bval    <= '1;
                    DivZero <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign HEX0 = seg7(Bval[3:0]);
    assign HEX1 = seg7(Bval[7:4]);
    assign HEX2 = seg7(Aval[3:0]);
    assign HEX3 = seg7(Aval[7:4]);

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
// ============================================================================
// tb_divider -- directed vector bench for the signed restoring divider
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_divider;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       Reset_Load_Clear;
    logic [7:0] SW;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       DivZero;
    logic       Ovf;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
    } vec_t;

    vec_t       vecs [14];
    logic [6:0] SEG  [16];

    divider #(.WIDTH(8), .HEX_ACTIVE_LOW(1'b1)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Run              (Run),
        .Reset_Load_Clear (Reset_Load_Clear),
        .SW               (SW),
        .Aval             (Aval),
        .Bval             (Bval),
        .DivZero          (DivZero),
        .Ovf              (Ovf),
        .HEX0             (HEX0),
        .HEX1             (HEX1),
        .HEX2             (HEX2),
        .HEX3             (HEX3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge Clk);
        SW = v;
        Reset_Load_Clear = 1'b0;
        tick(4);
        @(negedge Clk);
        Reset_Load_Clear = 1'b1;
        tick(4);
    endtask

    task automatic run_start(input logic [7:0] d);
        @(negedge Clk);
        SW  = d;
        Run = 1'b0;
    endtask

    task automatic run_release();
        @(negedge Clk);
        Run = 1'b1;
        tick(5);
    endtask

    task automatic check_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                                input logic dz, input logic ovf);
        check({tag, " Bval"},    Bval,            q);
        check({tag, " Aval"},    Aval,            r);
        check({tag, " DivZero"}, {7'd0, DivZero}, {7'd0, dz});
        check({tag, " Ovf"},     {7'd0, Ovf},     {7'd0, ovf});
    endtask

    task automatic check_hex(input string tag, input logic [7:0] q, input logic [7:0] r);
        check({tag, " HEX0"}, {1'b0, HEX0}, {1'b0, SEG[q[3:0]]});
        check({tag, " HEX1"}, {1'b0, HEX1}, {1'b0, SEG[q[7:4]]});
        check({tag, " HEX2"}, {1'b0, HEX2}, {1'b0, SEG[r[3:0]]});
        check({tag, " HEX3"}, {1'b0, HEX3}, {1'b0, SEG[r[7:4]]});
    endtask

    initial begin
        SEG[0]  = 7'h40; SEG[1]  = 7'h79; SEG[2]  = 7'h24; SEG[3]  = 7'h30;
        SEG[4]  = 7'h19; SEG[5]  = 7'h12; SEG[6]  = 7'h02; SEG[7]  = 7'h78;
        SEG[8]  = 7'h00; SEG[9]  = 7'h10; SEG[10] = 7'h08; SEG[11] = 7'h03;
        SEG[12] = 7'h46; SEG[13] = 7'h21; SEG[14] = 7'h06; SEG[15] = 7'h0E;

        //          dividend  divisor   quot      rem       dz    ovf
        vecs[0]  = '{8'h3B,   8'h07,    8'h08,    8'h03,    1'b0, 1'b0};
        vecs[1]  = '{8'hC5,   8'h07,    8'hF8,    8'hFD,    1'b0, 1'b0};
        vecs[2]  = '{8'h3B,   8'hF9,    8'hF8,    8'h03,    1'b0, 1'b0};
        vecs[3]  = '{8'hC5,   8'hF9,    8'h08,    8'hFD,    1'b0, 1'b0};
        vecs[4]  = '{8'h3B,   8'h00,    8'hFF,    8'h3B,    1'b1, 1'b0};
        vecs[5]  = '{8'h80,   8'hFF,    8'h80,    8'h00,    1'b0, 1'b1};
        vecs[6]  = '{8'h80,   8'h01,    8'h80,    8'h00,    1'b0, 1'b0};
        vecs[7]  = '{8'h7F,   8'h7F,    8'h01,    8'h00,    1'b0, 1'b0};
        vecs[8]  = '{8'h05,   8'h0A,    8'h00,    8'h05,    1'b0, 1'b0};
        vecs[9]  = '{8'h81,   8'h02,    8'hC1,    8'hFF,    1'b0, 1'b0};
        vecs[10] = '{8'h00,   8'h05,    8'h00,    8'h00,    1'b0, 1'b0};
        vecs[11] = '{8'h80,   8'h80,    8'h01,    8'h00,    1'b0, 1'b0};
        vecs[12] = '{8'h64,   8'h80,    8'h00,    8'h64,    1'b0, 1'b0};
        vecs[13] = '{8'h80,   8'h03,    8'hD6,    8'hFE,    1'b0, 1'b0};

        Reset = 1'b0;
        Run = 1'b1;
        Reset_Load_Clear = 1'b1;
        SW = 8'h00;
        tick(3);
        check_result("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        check_hex("reset", 8'h00, 8'h00);
        @(negedge Clk);
        Reset = 1'b1;
        tick(3);

        // Table of divisions, each from a fresh load.
        for (int i = 0; i < 14; i++) begin
            load(vecs[i].dvd);
            check($sformatf("vec%0d load", i), Bval, vecs[i].dvd);
            run_start(vecs[i].dvs);
            tick(14);
            check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ovf);
            check_hex($sformatf("vec%0d", i), vecs[i].q, vecs[i].r);
            run_release();
        end

        // Latency: results land on the 11th edge after sync Run is seen low.
        load(8'h3B);
        run_start(8'h07);
        tick(12);
        check("lat pre Bval", Bval, 8'h3B);
        check("lat pre Aval", Aval, 8'h00);
        tick(1);
        check("lat post Bval", Bval, 8'h08);
        check("lat post Aval", Aval, 8'h03);
        run_release();

        // Divide-by-zero completes on the 3rd edge.
        load(8'h3B);
        run_start(8'h00);
        tick(4);
        check("dz pre DivZero", {7'd0, DivZero}, 8'h00);
        check("dz pre Bval", Bval, 8'h3B);
        tick(1);
        check_result("dz post", 8'hFF, 8'h3B, 1'b1, 1'b0);
        run_release();

        // Long Run hold gives one division; result chains into the next Run.
        load(8'h64);
        run_start(8'h03);
        tick(40);
        check_result("hold", 8'h21, 8'h01, 1'b0, 1'b0);
        run_release();
        run_start(8'h03);
        tick(14);
        check_result("chain", 8'h0B, 8'h00, 1'b0, 1'b0);
        run_release();

        // Load pulse while iterating must not disturb the operation.
        load(8'h64);
        run_start(8'h03);
        tick(5);
        @(negedge Clk);
        Reset_Load_Clear = 1'b0;
        tick(2);
        @(negedge Clk);
        Reset_Load_Clear = 1'b1;
        tick(3);
        check("rlc mid Bval", Bval, 8'h64);
        tick(3);
        check_result("rlc", 8'h21, 8'h01, 1'b0, 1'b0);
        run_release();

        // Reset during iteration cnt=4 clears everything immediately.
        load(8'h3B);
        run_start(8'h07);
        tick(14);
        run_release();
        run_start(8'h03);
        tick(8);
        @(negedge Clk);
        Reset = 1'b0;
        Run = 1'b1;
        #1;
        check_result("abort", 8'h00, 8'h00, 1'b0, 1'b0);
        tick(2);
        @(negedge Clk);
        Reset = 1'b1;
        tick(15);
        check_result("abort idle", 8'h00, 8'h00, 1'b0, 1'b0);
        load(8'hC5);
        run_start(8'h07);
        tick(14);
        check_result("after abort", 8'hF8, 8'hFD, 1'b0, 1'b0);
        run_release();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
